mem_access_unit: RTL and testbench

Load/store sequencer between the MEM pipeline stage and the byte-addressed, word-ported data memory. It accepts one load or store request at a time and issues the word read and write strobes to the memory. Sub-word stores are performed as read-modify-write. Load data is extracted and extended, and a single response is returned per request together with an error flag.

---
 rtl/mem_access_unit.sv | 205 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a word-ported data memory.
// Optional MAU_ALIGN_CHECK_EN rejects misaligned halfword/word accesses.
module mem_access_unit #(
    parameter int unsigned ADDR_LIMIT = 64
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RespValid,
    output logic [31:0] RespData,
    output logic        RespError,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] MemReadData,
    input  logic        MemError
);

    localparam logic [31:0] LAST_WORD = 32'(ADDR_LIMIT - 4);
    localparam logic [1:0]  SZ_BYTE   = 2'b00;
    localparam logic [1:0]  SZ_HALF   = 2'b01;
    localparam logic [1:0]  SZ_WORD   = 2'b10;
    localparam logic [1:0]  SZ_ILL    = 2'b11;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_error_q, resp_error_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        accept;
    logic        misaligned;
    logic        req_error;

    // Insert store data into the lanes selected by size and byte offset.
    function automatic logic [31:0] merge_word(input logic [31:0] base, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] w;
        w = base;
        case (size)
            SZ_BYTE: w[{lane, 3'b000} +: 8]       = wdata[7:0];
            SZ_HALF: w[{lane[1], 4'b0000} +: 16]  = wdata[15:0];
            default: w                            = wdata;
        endcase
        return w;
    endfunction

    // Pick the addressed byte/halfword and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] data, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = data[{lane, 3'b000} +: 8];
        h = data[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = data;
        endcase
        return r;
    endfunction

    assign ReqReady = (state_q == IDLE) && Rst;
    assign accept   = ReqValid && ReqReady;

`ifdef MAU_ALIGN_CHECK_EN
    assign misaligned = ((ReqSize == SZ_WORD) && (ReqAddr[1:0] != 2'b00)) ||
                        ((ReqSize == SZ_HALF) && ReqAddr[0]);
`else
    assign misaligned = 1'b0;
`endif

    assign req_error = (ReqSize == SZ_ILL) || ({ReqAddr[31:2], 2'b00} > LAST_WORD) || misaligned;

    // Next-state and next-output decode; outputs are registered from the target state.
    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        size_d        = size_q;
        signed_d      = signed_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        resp_valid_d  = 1'b0;
        resp_error_d  = 1'b0;
        resp_data_d   = resp_data_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        mem_address_d = 32'h0;
        mem_wdata_d   = 32'h0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d  = ReqWrite;
                    size_d   = ReqSize;
                    signed_d = ReqSigned;
                    addr_d   = ReqAddr;
                    wdata_d  = ReqWData;
                    if (req_error) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_data_d  = 32'h0;
                    end else if (!ReqWrite || (ReqSize != SZ_WORD)) begin
                        state_d       = READ;
                        mem_read_d    = 1'b1;
                        mem_address_d = {ReqAddr[31:2], 2'b00};
                    end else begin
                        state_d       = WRITE;
                        mem_write_d   = 1'b1;
                        mem_address_d = {ReqAddr[31:2], 2'b00};
                        mem_wdata_d   = ReqWData;
                    end
                end
            end
            READ: begin
                if (MemError) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                    resp_data_d  = 32'h0;
                end else if (!write_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = load_extract(MemReadData, size_q, addr_q[1:0], signed_q);
                end else begin
                    state_d       = WRITE;
                    mem_write_d   = 1'b1;
                    mem_address_d = {addr_q[31:2], 2'b00};
                    mem_wdata_d   = merge_word(MemReadData, wdata_q, size_q, addr_q[1:0]);
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_data_d  = 32'h0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q       <= IDLE;
            write_q       <= 1'b0;
            size_q        <= 2'b00;
            signed_q      <= 1'b0;
            addr_q        <= 32'h0;
            wdata_q       <= 32'h0;
            resp_valid_q  <= 1'b0;
            resp_error_q  <= 1'b0;
            resp_data_q   <= 32'h0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= 32'h0;
            mem_wdata_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            resp_valid_q  <= resp_valid_d;
            resp_error_q  <= resp_error_d;
            resp_data_q   <= resp_data_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign RespValid    = resp_valid_q;
    assign RespError    = resp_error_q;
    assign RespData     = resp_data_q;
    assign MemRead      = mem_read_q;
    assign MemWrite     = mem_write_q;
    assign MemAddress   = mem_address_q;
    assign MemWriteData = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 64-byte word-ported memory model.
// Expectations follow MAU_ALIGN_CHECK_EN when the same macro is defined for the bench.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        mem_err;

    logic [31:0] mem [16];
    int          rd_cnt;
    int          wr_cnt;
    logic [31:0] last_wdata;
    int          n_cmp;
    int          n_bad;

    mem_access_unit #(.ADDR_LIMIT(64)) dut (
        .Clk(clk), .Rst(rst),
        .ReqValid(req_valid), .ReqReady(req_ready), .ReqWrite(req_write),
        .ReqSize(req_size), .ReqSigned(req_signed), .ReqAddr(req_addr), .ReqWData(req_wdata),
        .RespValid(resp_valid), .RespData(resp_data), .RespError(resp_error),
        .MemAddress(mem_address), .MemWriteData(mem_wdata),
        .MemRead(mem_read), .MemWrite(mem_write),
        .MemReadData(mem_rdata), .MemError(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = (mem_address < 32'd64) ? mem[mem_address[5:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_write && (mem_address < 32'd64)) mem[mem_address[5:2]] <= mem_wdata;
    end

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_read) rd_cnt = rd_cnt + 1;
        if (mem_write) begin
            wr_cnt     = wr_cnt + 1;
            last_wdata = mem_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request and wait (bounded) for its response; lat = 0 means no response.
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output int lat, output logic [31:0] data, output logic err,
                           output int rds, output int wrs);
        int rd0;
        int wr0;
        @(negedge clk);
        rd0        = rd_cnt;
        wr0        = wr_cnt;
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat  = 0;
        data = 32'hX;
        err  = 1'bX;
        for (int k = 1; k <= 8; k++) begin
            if (resp_valid) begin
                lat  = k;
                data = resp_data;
                err  = resp_error;
                break;
            end
            @(posedge clk);
            #1;
        end
        rds = rd_cnt - rd0;
        wrs = wr_cnt - wr0;
        @(posedge clk);
        #1;
        check_eq("resp_pulse_one_cycle", 32'(resp_valid), 32'h0);
    endtask

    int          lat;
    logic [31:0] data;
    logic        err;
    int          rds;
    int          wrs;

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rd_cnt     = 0;
        wr_cnt     = 0;
        last_wdata = 32'h0;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_err    = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        mem[4] <= 32'h8899AABB;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
        check_eq("rst_resp_error", 32'(resp_error), 32'h0);
        check_eq("rst_resp_data", resp_data, 32'h0);
        check_eq("rst_mem_read", 32'(mem_read), 32'h0);
        check_eq("rst_mem_write", 32'(mem_write), 32'h0);
        check_eq("rst_mem_address", mem_address, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        check_eq("rst_req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("ready_after_rst", 32'(req_ready), 32'h1);

        run_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, lat, data, err, rds, wrs);
        check_eq("lb_data", data, 32'hFFFFFF99);
        check_eq("lb_lat", 32'(lat), 32'd2);
        check_eq("lb_err", 32'(err), 32'h0);

        run_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, lat, data, err, rds, wrs);
        check_eq("lbu_data", data, 32'h00000099);

        run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, data, err, rds, wrs);
        check_eq("lh_data", data, 32'hFFFF8899);

        run_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, lat, data, err, rds, wrs);
`ifdef MAU_ALIGN_CHECK_EN
        check_eq("lw_mis_err", 32'(err), 32'h1);
        check_eq("lw_mis_lat", 32'(lat), 32'd1);
        check_eq("lw_mis_rd", 32'(rds), 32'd0);
`else
        check_eq("lw_mis_data", data, 32'h8899AABB);
        check_eq("lw_mis_err", 32'(err), 32'h0);
`endif

        run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, lat, data, err, rds, wrs);
        check_eq("sh_lat", 32'(lat), 32'd3);
        check_eq("sh_rd", 32'(rds), 32'd1);
        check_eq("sh_wr", 32'(wrs), 32'd1);
        check_eq("sh_wdata", last_wdata, 32'h1234AABB);
        check_eq("sh_resp_data", data, 32'h0);

        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, data, err, rds, wrs);
        check_eq("lw_after_sh", data, 32'h1234AABB);
        check_eq("lw_lat", 32'(lat), 32'd2);

        run_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000005A, lat, data, err, rds, wrs);
        run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, data, err, rds, wrs);
        check_eq("lhu_after_sb", data, 32'h00005A34);

        run_req(1'b1, 2'b10, 1'b0, 32'h3C, 32'hDEADBEEF, lat, data, err, rds, wrs);
        check_eq("sw_top_err", 32'(err), 32'h0);
        check_eq("sw_top_wr", 32'(wrs), 32'd1);
        check_eq("sw_top_rd", 32'(rds), 32'd0);
        check_eq("sw_top_lat", 32'(lat), 32'd2);
        check_eq("sw_top_mem", mem[15], 32'hDEADBEEF);

        run_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h11111111, lat, data, err, rds, wrs);
        check_eq("sw_oor_err", 32'(err), 32'h1);
        check_eq("sw_oor_lat", 32'(lat), 32'd1);
        check_eq("sw_oor_wr", 32'(wrs), 32'd0);

        mem_err = 1'b1;
        run_req(1'b1, 2'b00, 1'b0, 32'h10, 32'h000000EE, lat, data, err, rds, wrs);
        mem_err = 1'b0;
        check_eq("sb_memerr_err", 32'(err), 32'h1);
        check_eq("sb_memerr_wr", 32'(wrs), 32'd0);
        check_eq("sb_memerr_mem", mem[4], 32'h5A34AABB);

        run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, data, err, rds, wrs);
        check_eq("ill_size_err", 32'(err), 32'h1);
        check_eq("ill_size_lat", 32'(lat), 32'd1);
        check_eq("ill_size_rd", 32'(rds), 32'd0);

        // Reset while the READ cycle is in flight.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("mid_in_read", 32'(mem_read), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_valid", 32'(resp_valid), 32'h0);
        check_eq("mid_rst_read", 32'(mem_read), 32'h0);
        check_eq("mid_rst_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mid_ready_back", 32'(req_ready), 32'h1);
        check_eq("mid_no_resp", 32'(resp_valid), 32'h0);

        run_req(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, lat, data, err, rds, wrs);
        check_eq("post_rst_lw", data, 32'hDEADBEEF);
        check_eq("post_rst_lat", 32'(lat), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
